oled_spi_sink: RTL
==================

// Module: oled_spi_sink
// PURPOSE
// - Responder end of the OLED serial link: receives SCLK/SDIN/DC/RES/VDD/VBAT as driven by OLEDCtrl.
// - Deserialises bytes, decodes the SSD1306 page-addressing command subset, and mirrors GDDRAM writes into a 128x32 frame buffer.
// - Used as a synthesizable display model in loopback benches and for on-board mirroring of OLED contents. Pins are asynchronous to clk.
// PARAMETERS
// - SYNC_STAGES  2    synchroniser flops on sclk/sdin/dc/res_n (min 2)
// - NUM_COLS     128  columns per page
// - NUM_PAGES    4    8-row pages (128x32 panel)
// PORTS
// - clk          in   1  system clock; must be >= 4x SCLK frequency
// - rst          in   1  synchronous, active-high reset
// - sclk         in   1  serial clock from master; idle high
// - sdin         in   1  serial data, MSB first, sampled on sclk rising edge
// - dc           in   1  0 = command byte, 1 = GDDRAM data byte; sampled with bit 0 of each byte
// - res_n        in   1  panel reset, active low
// - vdd_n, vbat_n in  1  supply enables, active low
// - byte_valid   out  1  1-cycle pulse per received byte
// - byte_data    out  8  last received byte
// - byte_is_data out  1  dc value latched with byte_data
// - disp_on      out  1  0xAF sets, 0xAE clears
// - entire_on    out  1  0xA5 sets, 0xA4 clears
// - cur_page     out  2  page pointer
// - cur_col      out  7  column pointer
// - power_ok     out  1  registered ~vdd_n & ~vbat_n
// - rd_addr      in   9  {page[1:0], col[6:0]} frame-buffer read address
// - rd_data      out  8  frame-buffer byte, bit 0 = top row of page
// BEHAVIOUR
// - Reset (rst, or synchronised res_n low): all outputs 0; bit counter, arg state, page and col cleared. Frame buffer contents NOT cleared.
// - Receive: SYNC_STAGES-deep sync, rising-edge detect on sclk. Each edge shifts sdin into shift[7:0] and increments bit_cnt[2:0].
// - On the 8th bit: byte_data/byte_is_data update and byte_valid pulses.
// - Latency: byte_valid is asserted SYNC_STAGES+1 clk after the 8th sclk rising edge at the pins.
// - Decoder FSM, two states: CMD and ARG.
//   - CMD, data byte: write fb[{page,col}]; col <= col+1, wrapping 127 -> 0 with page unchanged.
//   - CMD, command byte:
//     - 0xB0-0xB7: page <= byte[1:0] (byte[2] ignored).
//     - 0x00-0x0F: col[3:0] <= byte[3:0].
//     - 0x10-0x17: col[6:4] <= byte[2:0].
//     - 0xAE/0xAF: disp_on. 0xA4/0xA5: entire_on.
//     - 0x20 0x81 0x8D 0xA8 0xD3 0xD5 0xD9 0xDA 0xDB: args_left <= 1, go to ARG.
//     - 0x21 0x22: args_left <= 2, go to ARG.
//     - Any other command: ignored.
//   - ARG: every byte, regardless of dc, is consumed and discarded; args_left decrements; at 0 return to CMD.
// - Addressing mode is always page mode; the 0x20 argument is ignored.
// - Frame buffer: 512x8 dual-port; write as above; rd_data registered, 1-cycle latency. Read and write to the same address in the same cycle returns the old data.
// - Reset mid-byte: partial bits are discarded; the next sclk edge is bit 7 of a new byte.
// - Reset mid-command: ARG is abandoned and the FSM returns to CMD.
// - sclk edges while res_n is low are ignored.
// CONFIGURATION
// - OLED_SINK_CS_EN defined: adds input cs_n (1 bit, active low, synchronised like sclk).
//   - cs_n high clears bit_cnt and masks sclk edges.
//   - Rising edge of cs_n mid-byte drops the partial byte.
// - OLED_SINK_CS_EN undefined: no cs_n port; framing relies solely on bit_cnt and resets.
// TESTING
// - Reset, then send cmd 0xAF -> disp_on=1; byte_valid one pulse, byte_data=0xAF, byte_is_data=0.
// - Cmds 0xB2,0x05,0x13 then data 0x3C -> fb[0x135]=0x3C, cur_col=0x36, cur_page=2.
// - col=127, page=1, data 0xAA,0x55 -> fb[0x0FF]=0xAA, fb[0x080]=0x55, cur_page=1.
// - Cmds 0x81,0xAF (0xAF as argument), then 0xA5 -> disp_on unchanged, entire_on=1.
// - Cmd 0x22 + args 0x00,0x03 -> no state change, FSM back in CMD.
// - 4 bits sent, res_n pulsed low, then full 0xAE -> byte_data=0xAE; page=col=0; prior fb data intact.
// - With OLED_SINK_CS_EN: cs_n rises after 3 bits, then byte 0xA5 -> entire_on=1, no spurious byte_valid.

Source files
------------

// File: rtl/oled_spi_sink.sv
// Responder for the OLED serial link: deserialises SCLK/SDIN bytes, decodes the page-mode command subset
// and mirrors GDDRAM writes into a 128x32 frame buffer. Optional chip select: define OLED_SINK_CS_EN.
//
// state | meaning
// CMD   | next byte is a command or a GDDRAM data byte
// ARG   | consuming argument bytes of a multi-byte command, args_left remaining
module oled_spi_sink #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_COLS    = 128,
    parameter int NUM_PAGES   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sdin,
    input  logic       dc,
    input  logic       res_n,
`ifdef OLED_SINK_CS_EN
    input  logic       cs_n,
`endif
    input  logic       vdd_n,
    input  logic       vbat_n,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_is_data,
    output logic       disp_on,
    output logic       entire_on,
    output logic [1:0] cur_page,
    output logic [6:0] cur_col,
    output logic       power_ok,
    input  logic [8:0] rd_addr,
    output logic [7:0] rd_data
);

    localparam int FB_DEPTH = NUM_COLS * NUM_PAGES;

    typedef enum logic {ST_CMD = 1'b0, ST_ARG = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sdin_sync;
    logic [SYNC_STAGES-1:0] r_dc_sync;
    logic [SYNC_STAGES-1:0] r_res_sync;
    logic                   r_sclk_prev;

    logic       w_sclk_s;
    logic       w_sdin_s;
    logic       w_dc_s;
    logic       w_rst;
    logic       w_cs_act;
    logic       w_rise;

    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic       r_byte_valid;
    logic [7:0] r_byte_data;
    logic       r_byte_is_data;
    logic       r_power_ok;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_args_left;
    logic [1:0] w_args_nxt;
    logic [1:0] w_nargs;
    logic [1:0] r_page;
    logic [1:0] w_page_nxt;
    logic [6:0] r_col;
    logic [6:0] w_col_nxt;
    logic       r_disp_on;
    logic       w_disp_nxt;
    logic       r_entire_on;
    logic       w_entire_nxt;
    logic       w_fb_we;

    logic [7:0] r_fb [FB_DEPTH];
    logic [7:0] r_rd_data;

    // sclk resets to idle-high so leaving reset never looks like a rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '1;
            r_sdin_sync <= '0;
            r_dc_sync   <= '0;
            r_res_sync  <= '0;
            r_sclk_prev <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_sdin_sync <= {r_sdin_sync[SYNC_STAGES-2:0], sdin};
            r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], dc};
            r_res_sync  <= {r_res_sync[SYNC_STAGES-2:0], res_n};
            r_sclk_prev <= w_sclk_s;
        end
    end

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_sdin_s = r_sdin_sync[SYNC_STAGES-1];
    assign w_dc_s   = r_dc_sync[SYNC_STAGES-1];
    assign w_rst    = rst | ~r_res_sync[SYNC_STAGES-1];

`ifdef OLED_SINK_CS_EN
    logic [SYNC_STAGES-1:0] r_cs_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_sync <= '1;
        end else begin
            r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
        end
    end

    assign w_cs_act = ~r_cs_sync[SYNC_STAGES-1];
`else
    assign w_cs_act = 1'b1;
`endif

    assign w_rise = w_sclk_s & ~r_sclk_prev & w_cs_act;

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_byte_valid   <= 1'b0;
            r_byte_data    <= '0;
            r_byte_is_data <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            if (!w_cs_act) begin
                r_bit_cnt <= '0;
            end else if (w_rise) begin
                r_shift   <= {r_shift[5:0], w_sdin_s};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_valid   <= 1'b1;
                    r_byte_data    <= {r_shift, w_sdin_s};
                    r_byte_is_data <= w_dc_s;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_power_ok <= 1'b0;
        end else begin
            r_power_ok <= ~vdd_n & ~vbat_n;
        end
    end

    // Argument count of multi-byte commands; the addressing-mode argument is discarded
    always_comb begin
        w_nargs = 2'd0;
        if (!r_byte_is_data) begin
            case (r_byte_data)
                8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
                8'hD5, 8'hD9, 8'hDA, 8'hDB: w_nargs = 2'd1;
                8'h21, 8'h22:               w_nargs = 2'd2;
                default:                    w_nargs = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state <= ST_CMD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_byte_valid) begin
            case (r_state)
                ST_CMD: if (w_nargs != 2'd0) w_state_nxt = ST_ARG;
                ST_ARG: if (r_args_left == 2'd1) w_state_nxt = ST_CMD;
                default: w_state_nxt = ST_CMD;
            endcase
        end
    end

    always_comb begin
        w_fb_we      = 1'b0;
        w_page_nxt   = r_page;
        w_col_nxt    = r_col;
        w_disp_nxt   = r_disp_on;
        w_entire_nxt = r_entire_on;
        w_args_nxt   = r_args_left;
        if (r_byte_valid) begin
            case (r_state)
                ST_CMD: begin
                    if (r_byte_is_data) begin
                        w_fb_we   = 1'b1;
                        w_col_nxt = r_col + 7'd1;
                    end else if (r_byte_data[7:3] == 5'b10110) begin
                        w_page_nxt = r_byte_data[1:0];
                    end else if (r_byte_data[7:4] == 4'h0) begin
                        w_col_nxt = {r_col[6:4], r_byte_data[3:0]};
                    end else if (r_byte_data[7:3] == 5'b00010) begin
                        w_col_nxt = {r_byte_data[2:0], r_col[3:0]};
                    end else begin
                        case (r_byte_data)
                            8'hAE:   w_disp_nxt   = 1'b0;
                            8'hAF:   w_disp_nxt   = 1'b1;
                            8'hA4:   w_entire_nxt = 1'b0;
                            8'hA5:   w_entire_nxt = 1'b1;
                            default: w_args_nxt   = w_nargs;
                        endcase
                    end
                end
                ST_ARG: w_args_nxt = r_args_left - 2'd1;
                default: w_args_nxt = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_page      <= '0;
            r_col       <= '0;
            r_disp_on   <= 1'b0;
            r_entire_on <= 1'b0;
            r_args_left <= '0;
        end else begin
            r_page      <= w_page_nxt;
            r_col       <= w_col_nxt;
            r_disp_on   <= w_disp_nxt;
            r_entire_on <= w_entire_nxt;
            r_args_left <= w_args_nxt;
        end
    end

    // Not reset: the frame buffer survives panel resets like real GDDRAM
    always_ff @(posedge clk) begin
        if (w_fb_we) begin
            r_fb[{r_page, r_col}] <= r_byte_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_fb[rd_addr];
        end
    end

    assign byte_valid   = r_byte_valid;
    assign byte_data    = r_byte_data;
    assign byte_is_data = r_byte_is_data;
    assign disp_on      = r_disp_on;
    assign entire_on    = r_entire_on;
    assign cur_page     = r_page;
    assign cur_col      = r_col;
    assign power_ok     = r_power_ok;
    assign rd_data      = r_rd_data;

endmodule
